// File: rtl/fphub_div_controller_if.sv
// Operand and result handshakes between the FPHUB divider controller and its client.
interface fphub_div_controller_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [2:0]   out_flags;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fphub_div_controller.sv
// Sequencing controller for the FPHUB divider: registers an operand pair,
// resolves special cases directly or runs the iterative core under a
// timeout guard, and hands the quotient and flags back to the client.
//
// state | meaning
// IDLE  | waiting for an operand pair
// CHECK | registered operands at the detector, special cases resolved
// RUN   | core running, timeout counter advancing
// OUT   | result presented until the client accepts it
module fphub_div_controller #(
    parameter int M            = 23,
    parameter int E            = 8,
    parameter int special_case = 7,
    parameter int TIMEOUT      = 64
) (
    input  logic                              clk,
    input  logic                              rst_l,
    fphub_div_controller_if.slave             bus,
    output logic [E+M:0]                      op_x,
    output logic [E+M:0]                      op_y,
    input  logic [$clog2(special_case)-1:0]   x_case,
    input  logic [$clog2(special_case)-1:0]   y_case,
    output logic                              core_start,
    input  logic                              core_done,
    input  logic [E+M:0]                      core_result,
    output logic                              busy
);
    localparam int W  = E + M + 1;
    localparam int CW = $clog2(special_case);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] C_PINF  = CW'(1);
    localparam logic [CW-1:0] C_NINF  = CW'(2);
    localparam logic [CW-1:0] C_PZERO = CW'(3);
    localparam logic [CW-1:0] C_NZERO = CW'(4);
    localparam logic [CW-1:0] C_PONE  = CW'(5);
    localparam logic [CW-1:0] C_NONE  = CW'(6);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, OUT} state_t;

    state_t         state, state_next;
    logic [W-1:0]   opx_next, opy_next;
    logic [W-1:0]   res, res_next;
    logic [2:0]     flags, flags_next;
    logic [TW-1:0]  cnt, cnt_next;
    logic           x_inf, y_inf, x_zero, y_zero, y_one, sign;

    assign x_inf  = (x_case == C_PINF)  || (x_case == C_NINF);
    assign y_inf  = (y_case == C_PINF)  || (y_case == C_NINF);
    assign x_zero = (x_case == C_PZERO) || (x_case == C_NZERO);
    assign y_zero = (y_case == C_PZERO) || (y_case == C_NZERO);
    assign y_one  = (y_case == C_PONE)  || (y_case == C_NONE);
    assign sign   = op_x[W-1] ^ op_y[W-1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst_l) state <= IDLE;
        else       state <= state_next;
    end

    // Operand, result, flag and timeout-counter registers.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            op_x  <= '0;
            op_y  <= '0;
            res   <= '0;
            flags <= '0;
            cnt   <= '0;
        end else begin
            op_x  <= opx_next;
            op_y  <= opy_next;
            res   <= res_next;
            flags <= flags_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and datapath update; special cases take priority top to bottom.
    always_comb begin
        state_next = state;
        opx_next   = op_x;
        opy_next   = op_y;
        res_next   = res;
        flags_next = flags;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    opx_next   = bus.in_x;
                    opy_next   = bus.in_y;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                cnt_next   = '0;
                state_next = OUT;
                flags_next = 3'b000;
                if ((x_inf && y_inf) || (x_zero && y_zero)) begin
                    res_next   = {sign, {(W-1){1'b1}}};
                    flags_next = 3'b001;
                end else if (x_inf) begin
                    res_next = {sign, {(W-1){1'b1}}};
                end else if (y_inf) begin
                    res_next = {sign, {(W-1){1'b0}}};
                end else if (x_zero) begin
                    res_next = {sign, {(W-1){1'b0}}};
                end else if (y_zero) begin
                    res_next   = {sign, {(W-1){1'b1}}};
                    flags_next = 3'b010;
                end else if (y_one) begin
                    res_next = {sign, op_x[W-2:0]};
                end else begin
                    flags_next = flags;
                    state_next = RUN;
                end
            end
            RUN: begin
                // A done arriving on the timeout cycle still delivers the quotient.
                if (core_done) begin
                    res_next   = core_result;
                    flags_next = 3'b000;
                    state_next = OUT;
                end else if (cnt == TW'(TIMEOUT - 1)) begin
                    res_next   = '0;
                    flags_next = 3'b100;
                    state_next = OUT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            OUT: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter only reads zero in the first RUN cycle, giving a single start pulse.
    assign core_start     = (state == RUN) && (cnt == '0);
    assign busy           = (state != IDLE);
    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == OUT);
    assign bus.out_result = res;
    assign bus.out_flags  = flags;
endmodule

// File: tb/tb_fphub_div_controller.sv
// Bench for fphub_div_controller: acts as detector, core and client, and
// compares every transaction with a rule-level reference model.
module tb_fphub_div_controller;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [31:0] op_x, op_y;
    logic [2:0]  x_case, y_case;
    logic        core_start;
    logic        core_done;
    logic [31:0] core_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fphub_div_controller_if #(.W(32)) bus ();

    fphub_div_controller #(.M(23), .E(8), .special_case(7), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .bus         (bus),
        .op_x        (op_x),
        .op_y        (op_y),
        .x_case      (x_case),
        .y_case      (y_case),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_result (core_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Detector model: exponent all ones = inf, all zeros = zero, 0x80 with empty mantissa = one.
    function automatic logic [2:0] det(input logic [31:0] v);
        if (v[30:23] == 8'hFF) return v[31] ? 3'd2 : 3'd1;
        if (v[30:23] == 8'h00) return v[31] ? 3'd4 : 3'd3;
        if (v[30:23] == 8'h80 && v[22:0] == 23'h0) return v[31] ? 3'd6 : 3'd5;
        return 3'd0;
    endfunction

    always_comb begin
        x_case = det(op_x);
        y_case = det(op_y);
    end

    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [2:0] f, output bit core);
        logic [2:0] cx, cy;
        bit xi, yi, xz, yz, yo, s;
        cx = det(x);
        cy = det(y);
        xi = (cx == 3'd1) || (cx == 3'd2);
        yi = (cy == 3'd1) || (cy == 3'd2);
        xz = (cx == 3'd3) || (cx == 3'd4);
        yz = (cy == 3'd3) || (cy == 3'd4);
        yo = (cy == 3'd5) || (cy == 3'd6);
        s  = x[31] ^ y[31];
        core = 1'b0;
        f = 3'b000;
        r = 32'h0;
        if ((xi && yi) || (xz && yz)) begin r = {s, 31'h7FFFFFFF}; f = 3'b001; end
        else if (xi) r = {s, 31'h7FFFFFFF};
        else if (yi) r = {s, 31'h0};
        else if (xz) r = {s, 31'h0};
        else if (yz) begin r = {s, 31'h7FFFFFFF}; f = 3'b010; end
        else if (yo) r = {s, x[30:0]};
        else core = 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 9))
            0: return {s, 8'hFF, 23'($urandom)};
            1: return {s, 31'h0};
            2: return {s, 8'h80, 23'h0};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // One full transaction; k is the RUN-cycle index on which the core reports done.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int k,
                          input logic [31:0] cr, input int rdly, input bit late);
        logic [31:0] er;
        logic [2:0]  ef;
        bit          core;
        int          cyc, elat;
        model(x, y, er, ef, core);
        elat = 0;
        if (core) begin
            if (k <= TO - 1) begin er = cr; ef = 3'b000; elat = k + 1; end
            else begin er = 32'h0; ef = 3'b100; elat = TO; end
        end
        bus.in_valid = 1'b1;
        bus.in_x = x;
        bus.in_y = y;
        chk("in_ready_idle", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_x = $urandom;
        bus.in_y = $urandom;
        chk("busy_check", busy, 1);
        chk("in_ready_check", bus.in_ready, 0);
        chk("op_x", op_x, x);
        chk("op_y", op_y, y);
        chk("start_in_check", core_start, 0);
        @(posedge clk); #1;
        if (!core) begin
            chk("special_valid", bus.out_valid, 1);
            chk("special_no_start", core_start, 0);
        end else begin
            chk("core_start_first", core_start, 1);
            chk("valid_run_entry", bus.out_valid, 0);
            cyc = 0;
            while (!bus.out_valid && cyc < TO + 5) begin
                if (cyc == k) begin core_done = 1'b1; core_result = cr; end
                @(posedge clk); #1;
                core_done = 1'b0;
                core_result = $urandom;
                if (!bus.out_valid) chk("start_single", core_start, 0);
                cyc++;
            end
            chk("core_latency", cyc, elat);
        end
        chk("out_result", bus.out_result, er);
        chk("out_flags", bus.out_flags, ef);
        chk("in_ready_out", bus.in_ready, 0);
        if (late) begin
            core_done = 1'b1;
            core_result = 32'hDEADBEEF;
        end
        for (int i = 0; i < rdly; i++) begin
            @(posedge clk); #1;
            core_done = 1'b0;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_result", bus.out_result, er);
            chk("hold_flags", bus.out_flags, ef);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        core_done = 1'b0;
        chk("valid_after_accept", bus.out_valid, 0);
        chk("in_ready_after_accept", bus.in_ready, 1);
        if (late) begin
            core_done = 1'b1;
            @(posedge clk); #1;
            core_done = 1'b0;
            chk("late_done_idle_valid", bus.out_valid, 0);
            chk("late_done_idle_busy", busy, 0);
        end
    endtask

    initial begin
        rst_l = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_x = 32'h0;
        bus.in_y = 32'h0;
        bus.out_ready = 1'b0;
        core_done = 1'b0;
        core_result = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_flags", bus.out_flags, 0);
        chk("rst_op_x", op_x, 0);
        chk("rst_op_y", op_y, 0);
        chk("rst_busy", busy, 0);
        rst_l = 1'b0;
        @(posedge clk); #1;

        run_op(32'h40C00000, 32'h00000000, 0, 32'h0, 0, 1'b0);
        run_op(32'h80000000, 32'h00000000, 0, 32'h0, 1, 1'b0);
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 0, 32'h0, 0, 1'b0);
        run_op(32'h3F812345, 32'hC0000000, 0, 32'h0, 0, 1'b0);
        run_op(32'h3F812345, 32'h3F900000, 5, 32'h12345678, 0, 1'b0);
        run_op(32'h3F812345, 32'h3F900000, TO + 2, 32'h0BADF00D, 2, 1'b1);
        run_op(32'h3F812345, 32'h3F900000, TO - 1, 32'h55AA55AA, 0, 1'b0);
        run_op(32'h3F812345, 32'h3F900000, TO, 32'h55AA55AA, 0, 1'b0);
        run_op(32'h40123456, 32'h3F900000, 0, 32'hCAFEF00D, 3, 1'b0);
        run_op(32'h00000000, 32'h7F800000, 0, 32'h0, 3, 1'b0);

        // Reset pulsed while the core is running discards the operation.
        bus.in_valid = 1'b1;
        bus.in_x = 32'h3F812345;
        bus.in_y = 32'h3F900000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rr_core_start", core_start, 1);
        @(posedge clk); #1;
        rst_l = 1'b1;
        @(posedge clk); #1;
        rst_l = 1'b0;
        chk("rr_in_ready", bus.in_ready, 1);
        chk("rr_out_valid", bus.out_valid, 0);
        chk("rr_busy", busy, 0);
        chk("rr_core_start_low", core_start, 0);
        chk("rr_op_x", op_x, 0);
        chk("rr_out_result", bus.out_result, 0);
        chk("rr_out_flags", bus.out_flags, 0);
        core_done = 1'b1;
        core_result = 32'hAAAA5555;
        @(posedge clk); #1;
        core_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rr_no_output", bus.out_valid, 0);
            chk("rr_idle", busy, 0);
            @(posedge clk); #1;
        end

        for (int n = 0; n < 40; n++) begin
            run_op(rand_op(), rand_op(), $urandom_range(0, TO + 2), $urandom,
                   $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
